// File: rtl/pitch_request_scheduler.sv
// pitch_request_scheduler
// Shares one pitch_adjuster between VOICES voice controllers. Pending
// (note, octave) requests are granted round-robin; a granted job is issued to
// the adjuster with the common C base pitch, and the adjuster's result is
// written into the granted voice's pitch register.
module pitch_request_scheduler #(
  parameter int VOICES     = 8,
  parameter int VOICE_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              base_pitch,
  input  logic [VOICES-1:0]        req_valid,
  input  logic [4*VOICES-1:0]      req_note,
  input  logic [2*VOICES-1:0]      req_octave,
  output logic [VOICES-1:0]        req_ack,
  output logic                     adj_start,
  output logic [15:0]              adj_reference_pitch,
  output logic [3:0]               adj_note,
  output logic [1:0]               adj_octave,
  input  logic [15:0]              adj_result,
  input  logic                     adj_result_valid,
  output logic [16*VOICES-1:0]     pitch_out,
  output logic [VOICES-1:0]        pitch_update,
  output logic [VOICES-1:0]        reject,
  output logic                     busy
);

  // Highest note index the adjuster understands (B); anything above is dropped.
  localparam logic [3:0] NOTE_MAX = 4'd11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_CLR  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [VOICE_BITS-1:0] rr_ptr;
  logic [VOICE_BITS-1:0] cur_voice;

  logic                  grant_found;
  logic [VOICE_BITS-1:0] grant_idx;
  logic [VOICE_BITS-1:0] next_ptr;
  logic [3:0]            grant_note;
  logic [1:0]            grant_octave;
  logic                  grant_ok;

  // rr_ptr + off, wrapped into 0..VOICES-1 (VOICES need not be a power of 2)
  function automatic logic [VOICE_BITS-1:0] wrap_idx(
    input logic [VOICE_BITS-1:0] base,
    input int                    off
  );
    int s;
    s = int'(base) + off;
    if (s >= VOICES) s = s - VOICES;
    return VOICE_BITS'(s);
  endfunction

  // Round-robin search: first pending request at or above rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!grant_found && req_valid[wrap_idx(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr, i);
      end
    end
  end

  // Operand extraction for the granted voice and the pointer after it
  always_comb begin
    grant_note   = req_note[{grant_idx, 2'b00} +: 4];
    grant_octave = req_octave[{grant_idx, 1'b0} +: 2];
    grant_ok     = (grant_note <= NOTE_MAX);
    next_ptr     = (int'(grant_idx) == VOICES - 1) ? '0
                                                   : grant_idx + VOICE_BITS'(1);
  end

  // Ack is only given while IDLE, in the same cycle the grant is decided
  always_comb begin
    req_ack = '0;
    if (state == IDLE && grant_found)
      req_ack = VOICES'(1) << grant_idx;
  end

  assign busy = (state != IDLE);

  // Scheduler FSM: grant, issue, skip the stale-valid cycle, then wait for done
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      cur_voice           <= '0;
      adj_start           <= 1'b0;
      adj_reference_pitch <= '0;
      adj_note            <= '0;
      adj_octave          <= '0;
      pitch_out           <= '0;
      pitch_update        <= '0;
      reject              <= '0;
    end else begin
      pitch_update <= '0;
      reject       <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            rr_ptr <= next_ptr;
            if (grant_ok) begin
              cur_voice           <= grant_idx;
              adj_note            <= grant_note;
              adj_octave          <= grant_octave;
              adj_reference_pitch <= base_pitch;
              adj_start           <= 1'b1;
              state               <= ISSUE;
            end else begin
              // Out-of-range note: drop it without touching the adjuster
              reject[grant_idx] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          adj_start <= 1'b0;
          state     <= WAIT_CLR;
        end
        WAIT_CLR: begin
          // adj_result_valid may still be the previous job's level here
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (adj_result_valid) begin
            pitch_out[{cur_voice, 4'b0000} +: 16] <= adj_result;
            pitch_update[cur_voice]               <= 1'b1;
            state                                 <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
